// File: rtl/ofdm_preamble_inserter_if.sv
// AXI-stream sample bus used on both sides of the preamble inserter.
// Samples are {I[31:16], Q[15:0]} at the default width.
interface ofdm_preamble_inserter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, tlast, tvalid, input  tready);
    modport slave  (input  tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/ofdm_preamble_inserter.sv
// Prepends NREP repetitions of a PLEN-sample training sequence to every packet,
// then passes the payload straight through with no added latency.
module ofdm_preamble_inserter #(
    parameter int BASE         = 0,
    parameter int WIDTH        = 32,
    parameter int MAX_LEN_LOG2 = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           set_stb,
    input  logic [7:0]                     set_addr,
    input  logic [31:0]                    set_data,
    ofdm_preamble_inserter_if.slave        i,
    ofdm_preamble_inserter_if.master       o
);
    localparam int LW    = MAX_LEN_LOG2 + 1;
    localparam int DEPTH = 1 << MAX_LEN_LOG2;

    localparam logic [7:0] A_PLEN = 8'(BASE);
    localparam logic [7:0] A_NREP = 8'(BASE + 1);
    localparam logic [7:0] A_PTR  = 8'(BASE + 2);
    localparam logic [7:0] A_DATA = 8'(BASE + 3);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    state_t                  state, nxt;
    logic [LW-1:0]           plen_r, plen_s, plen_wr;
    logic [7:0]              nrep_r, nrep_s;
    logic [MAX_LEN_LOG2-1:0] ptr;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [LW-1:0]           idx;
    logic [7:0]              rep;
    logic                    last_idx, last_rep;

    // Period 0 is meaningless and anything beyond the memory depth would read
    // past the table, so the stored period is clamped to [1, DEPTH].
    always_comb begin
        plen_wr = set_data[LW-1:0];
        if (set_data == 32'd0)
            plen_wr = LW'(1);
        else if (set_data > 32'(DEPTH))
            plen_wr = LW'(DEPTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plen_r <= LW'(16);
            nrep_r <= 8'd10;
            ptr    <= '0;
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else if (set_stb) begin
            case (set_addr)
                A_PLEN: plen_r <= plen_wr;
                A_NREP: nrep_r <= set_data[7:0];
                A_PTR:  ptr    <= set_data[MAX_LEN_LOG2-1:0];
                A_DATA: begin
                    mem[ptr] <= set_data[WIDTH-1:0];
                    ptr      <= ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign last_idx = (idx == plen_s - LW'(1));
    assign last_rep = (rep == nrep_s - 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (i.tvalid) nxt = (nrep_r != 8'd0) ? PREAMBLE : PAYLOAD;
            PREAMBLE: if (o.tready && last_idx && last_rep) nxt = PAYLOAD;
            PAYLOAD:  if (i.tvalid && o.tready && i.tlast) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (clear)
            nxt = IDLE;
    end

    always_comb begin
        o.tvalid = 1'b0;
        o.tlast  = 1'b0;
        o.tdata  = '0;
        i.tready = 1'b0;
        case (state)
            PREAMBLE: begin
                o.tvalid = 1'b1;
                o.tdata  = mem[idx[MAX_LEN_LOG2-1:0]];
            end
            PAYLOAD: begin
                o.tvalid = i.tvalid;
                o.tlast  = i.tlast;
                o.tdata  = i.tdata;
                i.tready = o.tready;
            end
            default: ;
        endcase
    end

    // Geometry is frozen when a packet starts so that mid-packet writes only
    // affect the following packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plen_s <= LW'(16);
            nrep_s <= 8'd10;
        end else if (state == IDLE && i.tvalid && !clear) begin
            plen_s <= plen_r;
            nrep_s <= nrep_r;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            rep <= '0;
        end else if (clear || state != PREAMBLE) begin
            idx <= '0;
            rep <= '0;
        end else if (o.tready) begin
            if (last_idx) begin
                idx <= '0;
                rep <= last_rep ? 8'd0 : rep + 8'd1;
            end else begin
                idx <= idx + LW'(1);
            end
        end
    end
endmodule
